// File: rtl/lc3_pkg.sv
// Shared LC-3 constants for the writeback path.
//   REG_CNT  : number of architectural registers (R0..R7)
//   DR_W     : width of a destination-register index
//   WORD_W   : ISA data width
//   CC_*     : {N,Z,P} condition-code encodings and the reset value
package lc3_pkg;

    localparam int REG_CNT = 8;
    localparam int DR_W    = 3;
    localparam int WORD_W  = 16;

    localparam logic [2:0] CC_N     = 3'b100;
    localparam logic [2:0] CC_Z     = 3'b010;
    localparam logic [2:0] CC_P     = 3'b001;
    localparam logic [2:0] CC_RESET = CC_Z;

endpackage

// File: rtl/wb_dr_decode.sv
// Combinational 3-to-8 one-hot decoder for the granted destination register.
//   dr     : register index (R0..R7)
//   onehot : bit dr set, all others clear
module wb_dr_decode
    import lc3_pkg::*;
(
    input  logic [DR_W-1:0]    dr,
    output logic [REG_CNT-1:0] onehot
);

    always_comb begin
        onehot     = '0;
        onehot[dr] = 1'b1;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file's single write port among REQ_N writeback sources
// (0 = ALU, 1 = LD, 2 = JSR/TRAP link) with round-robin arbitration, owns the
// NZP condition codes and a per-register busy scoreboard for the issue stage.
//
// Handshake: source i presents req_valid[i] with dr/data/setcc held stable;
// req_ready is a combinational one-hot grant computed from req_valid and the
// round-robin pointer only. A transfer occurs at the edge where
// req_valid[i] & req_ready[i]; its write appears on rf_we/rf_wdata for
// exactly the following cycle.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/dr/data/setcc: per-source write requests (packed by index)
//   req_ready             : one-hot grant (0 while in reset)
//   rsv_valid, rsv_dr     : issue-stage reservation of a destination reg
//   rf_we, rf_wdata       : registered one-hot write enable and data
//   cc                    : registered {N,Z,P}
//   busy                  : registered scoreboard, bit r = pending result
module regfile_wb_scheduler
    import lc3_pkg::*;
#(
    parameter int REQ_N  = 3,
    parameter int WORD_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQ_N-1:0]          req_valid,
    input  logic [DR_W*REQ_N-1:0]     req_dr,
    input  logic [WORD_W*REQ_N-1:0]   req_data,
    input  logic [REQ_N-1:0]          req_setcc,
    output logic [REQ_N-1:0]          req_ready,
    input  logic                      rsv_valid,
    input  logic [DR_W-1:0]           rsv_dr,
    output logic [REG_CNT-1:0]        rf_we,
    output logic [WORD_W-1:0]         rf_wdata,
    output logic [2:0]                cc,
    output logic [REG_CNT-1:0]        busy
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [REQ_N-1:0]   grant;
    logic               found;
    logic [PTR_W-1:0]   gnt_idx;
    logic [DR_W-1:0]    gnt_dr;
    logic [WORD_W-1:0]  gnt_data;
    logic               gnt_setcc;
    logic [2:0]         gnt_cc;
    logic [REG_CNT-1:0] gnt_onehot;
    logic [REG_CNT-1:0] busy_next;

    // Round-robin search: first pass covers indices ptr..REQ_N-1, second
    // pass wraps to 0..ptr-1. Only req_valid and ptr feed this logic.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (!found && req_valid[i] && (PTR_W'(i) >= ptr)) begin
                grant[i] = 1'b1;
                gnt_idx  = PTR_W'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < REQ_N; i++) begin
            if (!found && req_valid[i] && (PTR_W'(i) < ptr)) begin
                grant[i] = 1'b1;
                gnt_idx  = PTR_W'(i);
                found    = 1'b1;
            end
        end
        if (!rst_n) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign req_ready = grant;

    // Mux the winning source's payload using the one-hot grant.
    always_comb begin
        gnt_dr    = '0;
        gnt_data  = '0;
        gnt_setcc = 1'b0;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant[i]) begin
                gnt_dr    = req_dr[i*DR_W +: DR_W];
                gnt_data  = req_data[i*WORD_W +: WORD_W];
                gnt_setcc = req_setcc[i];
            end
        end
    end

    wb_dr_decode u_dr_decode (
        .dr     (gnt_dr),
        .onehot (gnt_onehot)
    );

    always_comb begin
        if (gnt_data[WORD_W-1]) begin
            gnt_cc = CC_N;
        end else if (gnt_data == '0) begin
            gnt_cc = CC_Z;
        end else begin
            gnt_cc = CC_P;
        end
    end

    // Clear on write first, then set on reserve: a reservation arriving in
    // the same cycle as a write to that register belongs to a newer
    // instruction and must survive.
    always_comb begin
        busy_next = busy;
        if (found) begin
            busy_next = busy_next & ~gnt_onehot;
        end
        if (rsv_valid) begin
            busy_next[rsv_dr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= '0;
            rf_wdata <= '0;
            cc       <= CC_RESET;
            busy     <= '0;
            ptr      <= '0;
        end else begin
            busy <= busy_next;
            if (found) begin
                rf_we    <= gnt_onehot;
                rf_wdata <= gnt_data;
                if (gnt_setcc) begin
                    cc <= gnt_cc;
                end
                if (gnt_idx == PTR_W'(REQ_N - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_idx + 1'b1;
                end
            end else begin
                rf_we <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios followed by randomized
// traffic. A reference model predicts the grant and the post-edge state each
// cycle; a monitor pops the expected state after every edge and compares.
module tb_regfile_wb_scheduler;

    localparam int REQ_N  = 3;
    localparam int WORD_W = 16;
    localparam int EXP_W  = 8 + 16 + 3 + 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [8:0]  req_dr = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  req_setcc = '0;
    logic [2:0]  req_ready;
    logic        rsv_valid = 1'b0;
    logic [2:0]  rsv_dr = '0;
    logic [7:0]  rf_we;
    logic [15:0] rf_wdata;
    logic [2:0]  cc;
    logic [7:0]  busy;

    regfile_wb_scheduler #(.REQ_N(REQ_N), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dr    (req_dr),
        .req_data  (req_data),
        .req_setcc (req_setcc),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_dr    (rsv_dr),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .cc        (cc),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference model state
    int          m_ptr   = 0;
    logic [2:0]  m_cc    = 3'b010;
    logic [7:0]  m_busy  = '0;
    logic [15:0] m_wdata = '0;
    int          last_g  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v == 16'h0000) return 3'b010;
        if ($signed(v) < 0) return 3'b100;
        return 3'b001;
    endfunction

    // ---------------- driver + model ----------------
    task automatic drive(input logic rst, input logic [2:0] v, input logic [8:0] dr,
                         input logic [47:0] data, input logic [2:0] sc,
                         input logic rv, input logic [2:0] rdr);
        int          g;
        int          idx;
        logic [2:0]  exp_ready;
        logic [7:0]  e_we;
        logic [2:0]  d;
        logic [15:0] w;
        @(negedge clk);
        rst_n     = rst;
        req_valid = v;
        req_dr    = dr;
        req_data  = data;
        req_setcc = sc;
        rsv_valid = rv;
        rsv_dr    = rdr;
        #1;
        // Winner: first valid source in circular order starting at the pointer.
        g = -1;
        if (rst) begin
            for (int k = 0; k < REQ_N; k++) begin
                idx = (m_ptr + k) % REQ_N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
        check("req_ready", 32'(req_ready), 32'(exp_ready));

        e_we = '0;
        if (!rst) begin
            m_ptr   = 0;
            m_cc    = 3'b010;
            m_busy  = '0;
            m_wdata = '0;
        end else begin
            if (g >= 0) begin
                d       = dr[3*g +: 3];
                w       = data[16*g +: 16];
                e_we    = 8'(1 << d);
                m_wdata = w;
                if (sc[g]) m_cc = cc_of(w);
                m_busy[d] = 1'b0;
                m_ptr   = (g + 1) % REQ_N;
            end
            if (rv) m_busy[rdr] = 1'b1;
        end
        exp_q.push_back({e_we, m_wdata, m_cc, m_busy});
        last_g = g;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we",    32'(rf_we),    32'(e[34:27]));
                check("rf_wdata", 32'(rf_wdata), 32'(e[26:11]));
                check("cc",       32'(cc),       32'(e[10:8]));
                check("busy",     32'(busy),     32'(e[7:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [2:0]  sv;
    logic [8:0]  sdr;
    logic [47:0] sdat;
    logic [2:0]  ssc;
    logic        rst_now;

    initial begin : stimulus
        // Reset held for two edges with every source requesting.
        drive(1'b0, 3'b111, 9'o765, 48'h1111_2222_3333, 3'b111, 1'b1, 3'd4);
        drive(1'b0, 3'b111, 9'o765, 48'h1111_2222_3333, 3'b111, 1'b1, 3'd4);

        // Round-robin with all sources valid: expect 0,1,2,0,1,2.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 3'b111, 9'(c * 73), {16'(c + 1), 16'h0, 16'hF00D}, 3'(c), 1'b0, 3'd0);
            check("rr_order", 32'(last_g), 32'(c % 3));
        end

        // Single write from source 1: R5 <= 8000, sets N.
        drive(1'b1, 3'b010, 9'o050, 48'h0000_8000_0000, 3'b010, 1'b0, 3'd0);
        drive(1'b1, 3'b000, 9'o000, 48'h0, 3'b000, 1'b0, 3'd0);

        // Positive setcc write to get cc=001, then a link write that leaves cc.
        drive(1'b1, 3'b001, 9'o001, 48'h0000_0000_0005, 3'b001, 1'b0, 3'd0);
        drive(1'b1, 3'b100, 9'o700, 48'h0000_0000_0000, 3'b000, 1'b0, 3'd0);
        drive(1'b1, 3'b000, 9'o000, 48'h0, 3'b000, 1'b0, 3'd0);

        // Scoreboard race on R3.
        drive(1'b1, 3'b000, 9'o000, 48'h0, 3'b000, 1'b1, 3'd3);
        drive(1'b1, 3'b001, 9'o003, 48'h0000_0000_1234, 3'b000, 1'b1, 3'd3);
        drive(1'b1, 3'b001, 9'o003, 48'h0000_0000_4321, 3'b000, 1'b0, 3'd0);
        drive(1'b1, 3'b000, 9'o000, 48'h0, 3'b000, 1'b1, 3'd6);

        // Reset in the grant cycle of a dr=2 write.
        drive(1'b0, 3'b001, 9'o002, 48'h0000_0000_FFFF, 3'b001, 1'b0, 3'd0);
        drive(1'b1, 3'b000, 9'o000, 48'h0, 3'b000, 1'b0, 3'd0);

        // Randomized traffic; sources hold their request until granted.
        sv = '0; sdr = '0; sdat = '0; ssc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < REQ_N; i++) begin
                if (!sv[i] && $urandom_range(0, 2) != 0) begin
                    sv[i]         = 1'b1;
                    sdr[3*i +: 3] = 3'($urandom_range(0, 7));
                    case ($urandom_range(0, 3))
                        0:       sdat[16*i +: 16] = 16'h0000;
                        1:       sdat[16*i +: 16] = 16'h8000 | 16'($urandom);
                        default: sdat[16*i +: 16] = 16'($urandom);
                    endcase
                    ssc[i] = 1'($urandom_range(0, 1));
                end
            end
            rst_now = ($urandom_range(0, 63) != 0);
            drive(rst_now, sv, sdr, sdat, ssc, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if (last_g >= 0) sv[last_g] = 1'b0;
        end
        drive(1'b1, 3'b000, 9'o000, 48'h0, 3'b000, 1'b0, 3'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
